// File: rtl/sume_adder.sv
// sume_adder: keypad-driven three-digit decimal adder.
// Six key codes are entered: first operand hundreds, tens, units, then
// second operand hundreds, tens, units. After the sixth digit the binary
// sum of the two operands is published on cdu and held until the next sum.
//
// Ports:
//   clk     system clock, all state on the rising edge
//   rst     asynchronous active-high reset
//   sample  4-bit key code: 0-9 digit, 4'b1111 no key, 10-14 invalid
//   cdu     registered binary sum, 0..1998
module sume_adder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sample,
    output logic [11:0] cdu
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [3:0] NO_KEY = 4'hF;

    typedef enum logic [2:0] {
        W1_H, W1_T, W1_U, W2_H, W2_T, W2_U, SUM
    } state_t;

    // Input conditioning
    logic [3:0]    sync1, sync2;
    logic [3:0]    last;       // most recent synchronized value being timed
    logic [CW-1:0] cnt;        // consecutive cycles 'last' has been seen
    logic [3:0]    stable;     // accepted debounced code
    logic          key_evt;    // one-cycle pulse per accepted digit
    logic [3:0]    key_digit;

    // Entry state
    state_t     state;
    logic [3:0] h1, t1, u1, h2, t2, u2;

    function automatic logic [9:0] bcd3_to_bin(input logic [3:0] h,
                                               input logic [3:0] t,
                                               input logic [3:0] u);
        logic [9:0] hh, tt, uu;
        hh = {6'b0, h};
        tt = {6'b0, t};
        uu = {6'b0, u};
        // x*100 = x*64 + x*32 + x*4, x*10 = x*8 + x*2
        return (hh << 6) + (hh << 5) + (hh << 2) + (tt << 3) + (tt << 1) + uu;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= NO_KEY;
            sync2     <= NO_KEY;
            last      <= NO_KEY;
            cnt       <= '0;
            stable    <= NO_KEY;
            key_evt   <= 1'b0;
            key_digit <= '0;
        end else begin
            sync1   <= sample;
            sync2   <= sync1;
            key_evt <= 1'b0;
            // Any change restarts the stability count from one sighting.
            if (sync2 != last) begin
                last <= sync2;
                cnt  <= CW'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            // Accept only a code that differs from the current stable one,
            // so a held key yields exactly one event.
            if (cnt == CNT_MAX && last != stable) begin
                stable    <= last;
                key_digit <= last;
                key_evt   <= (last <= 4'd9);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= W1_H;
            h1    <= '0;
            t1    <= '0;
            u1    <= '0;
            h2    <= '0;
            t2    <= '0;
            u2    <= '0;
            cdu   <= '0;
        end else begin
            case (state)
                W1_H: if (key_evt) begin h1 <= key_digit; state <= W1_T; end
                W1_T: if (key_evt) begin t1 <= key_digit; state <= W1_U; end
                W1_U: if (key_evt) begin u1 <= key_digit; state <= W2_H; end
                W2_H: if (key_evt) begin h2 <= key_digit; state <= W2_T; end
                W2_T: if (key_evt) begin t2 <= key_digit; state <= W2_U; end
                W2_U: if (key_evt) begin u2 <= key_digit; state <= SUM;  end
                SUM: begin
                    cdu   <= {1'b0, {1'b0, bcd3_to_bin(h1, t1, u1)}
                                  + {1'b0, bcd3_to_bin(h2, t2, u2)}};
                    state <= W1_H;
                end
                default: state <= W1_H;
            endcase
        end
    end

endmodule

// File: tb/tb_sume_adder.sv
// tb_sume_adder: scoreboard bench for sume_adder. Expected sums are pushed
// when the sixth digit is driven and popped once the result has settled.
module tb_sume_adder;

    localparam int DC = 4;
    localparam int HOLD = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sample;
    logic [11:0] cdu;

    int total = 0;
    int bad = 0;
    logic [11:0] sb[$];
    logic [11:0] last_sum;

    always #5 clk = ~clk;

    sume_adder #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk),
        .rst(rst),
        .sample(sample),
        .cdu(cdu)
    );

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic hold(input logic [3:0] code, input int cycles);
        sample = code;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] model(input logic [3:0] d[6]);
        int a, b;
        a = 100 * int'(d[0]) + 10 * int'(d[1]) + int'(d[2]);
        b = 100 * int'(d[3]) + 10 * int'(d[4]) + int'(d[5]);
        return 12'(a + b);
    endfunction

    task automatic pop_check(input string tag);
        logic [11:0] exp;
        @(negedge clk);
        if (sb.size() == 0) begin
            check({tag, "_empty"}, cdu, ~cdu);
        end else begin
            exp = sb.pop_front();
            check(tag, cdu, exp);
            last_sum = exp;
        end
    endtask

    task automatic entry(input string tag, input logic [3:0] d[6], input bit rel_each);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                @(negedge clk);
                check({tag, "_hold"}, cdu, last_sum);
                sb.push_back(model(d));
            end
            hold(d[i], HOLD);
            if (rel_each || i == 5) hold(4'hF, HOLD);
        end
        pop_check(tag);
    endtask

    initial begin
        logic [3:0] d[6];
        rst = 1'b1;
        sample = 4'hF;
        last_sum = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_cdu", cdu, 12'd0);

        d = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3};
        entry("first_sum", d, 1'b0);
        hold(4'hF, 20);
        @(negedge clk);
        check("first_stable", cdu, 12'h0F6);

        d = '{4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1};
        entry("back_to_back", d, 1'b0);

        d = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        entry("max_sum", d, 1'b1);

        d = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        entry("zero_sum", d, 1'b1);

        // Long hold of 5 counts once; 5,release,5 counts twice; a short
        // glitch to 7 and invalid code 12 must not advance the entry.
        hold(4'd5, 60);
        hold(4'hF, HOLD);
        hold(4'd5, HOLD);
        hold(4'hF, HOLD);
        hold(4'd7, 2);
        hold(4'hF, HOLD);
        hold(4'd12, HOLD);
        hold(4'hF, HOLD);
        hold(4'd0, HOLD);
        hold(4'hF, HOLD);
        hold(4'd0, HOLD);
        hold(4'hF, HOLD);
        hold(4'd0, HOLD);
        hold(4'hF, HOLD);
        @(negedge clk);
        check("repeat_hold", cdu, last_sum);
        sb.push_back(12'd553);
        hold(4'd3, HOLD);
        hold(4'hF, HOLD);
        pop_check("repeat_invalid");

        // Partial entry then an asynchronous mid-cycle reset.
        hold(4'd4, HOLD); hold(4'hF, HOLD);
        hold(4'd4, HOLD); hold(4'hF, HOLD);
        hold(4'd4, HOLD); hold(4'hF, HOLD);
        hold(4'd1, HOLD); hold(4'hF, HOLD);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("async_reset", cdu, 12'd0);
        last_sum = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        hold(4'hF, HOLD);
        d = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd2};
        entry("after_reset", d, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
